// File: rtl/lc3_mem_arbiter.sv
// Purpose: arbitrates one single-port memory between the LC-3 CPU and a debug/loader port, with a bounded debug lock.
// Latency: winner sampled at edge N drives the memory port in cycle N+1; read data and rvalid follow in cycle N+2.
// Backpressure: requesters hold req/payload until they see gnt; a port's req is ignored on the edge ending its own gnt cycle.
module lc3_mem_arbiter #(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_din,
    input  logic        dbg_lock,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [15:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE_CPU = 2'd1,
        ISSUE_DBG = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lock_cnt;
    logic [7:0] lock_cnt_nxt;
    logic [7:0] lock_cnt_inc;
    logic       last_dbg;       // 1 when the debug port was granted most recently
    logic       lock_expired;   // this edge ends the last cycle the lock may last
    logic       lock_hold;      // lock stays in force through this edge, CPU blocked
    logic       cpu_elig;
    logic       dbg_elig;
    logic       cpu_win;
    logic       dbg_win;

    // Arbitration and next-state: pick at most one winner per edge and track the lock.
    always_comb begin
        state_nxt    = IDLE;
        lock_cnt_nxt = 8'd0;
        lock_cnt_inc = lock_cnt + 8'd1;
        lock_expired = (state == LOCKED) && (lock_cnt_inc >= LOCK_LIMIT);
        lock_hold    = (state == LOCKED) && dbg_lock && !lock_expired;
        cpu_elig     = cpu_req && !cpu_gnt && !lock_hold;
        dbg_elig     = dbg_req && !dbg_gnt;
        // On a timeout exit the CPU takes the turn regardless of the pointer,
        // which also keeps the debug port from re-locking before that grant.
        cpu_win      = cpu_elig && (!dbg_elig || lock_expired || last_dbg);
        dbg_win      = dbg_elig && !cpu_win;

        if (lock_hold) begin
            state_nxt    = LOCKED;
            lock_cnt_nxt = lock_cnt_inc;
        end else if (dbg_win && dbg_lock) begin
            state_nxt    = LOCKED;
            lock_cnt_nxt = 8'd0;
        end else if (dbg_win) begin
            state_nxt = ISSUE_DBG;
        end else if (cpu_win) begin
            state_nxt = ISSUE_CPU;
        end
    end

    // State register, pointer and lock counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_cnt <= 8'd0;
            last_dbg <= 1'b1;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (cpu_win) begin
                last_dbg <= 1'b0;
            end else if (dbg_win) begin
                last_dbg <= 1'b1;
            end
        end
    end

    // Registered memory port and grant strobes; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 16'd0;
            mem_din  <= 16'd0;
            cpu_gnt  <= 1'b0;
            dbg_gnt  <= 1'b0;
        end else begin
            mem_en  <= cpu_win || dbg_win;
            cpu_gnt <= cpu_win;
            dbg_gnt <= dbg_win;
            mem_we  <= 1'b0;
            if (cpu_win) begin
                mem_we   <= cpu_we;
                mem_addr <= cpu_addr;
                mem_din  <= cpu_din;
            end else if (dbg_win) begin
                mem_we   <= dbg_we;
                mem_addr <= dbg_addr;
                mem_din  <= dbg_din;
            end
        end
    end

    // Read-valid follows the issuing port's read by one cycle; reset drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !mem_we;
            dbg_rvalid <= dbg_gnt && !mem_we;
        end
    end

    // Read data is only passed through while a read is returning, else zero.
    assign rdata = (cpu_rvalid || dbg_rvalid) ? mem_dout : 16'd0;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Purpose: self-checking bench for lc3_mem_arbiter against a cycle-level behavioural model.
// Latency: model predicts outputs one edge ahead; checks run on every falling edge.
// Backpressure: bench requesters hold req/payload until they observe their gnt.
module tb_lc3_mem_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'd0, cpu_din = 16'd0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [15:0] dbg_addr = 16'd0, dbg_din = 16'd0;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [15:0] rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_din;
    logic [15:0] mem_dout = 16'd0;

    int n_vec = 0;
    int n_bad = 0;

    lc3_mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        if (i == 32'h3000) return 16'hABCD;
        return 16'(i) ^ 16'h5A5A;
    endfunction

    // Synchronous single-port memory seen by the DUT.
    logic [15:0] mem [0:65535];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (mem_en === 1'b1) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] ref_mem [0:65535];
    bit          model_live = 0;
    bit          locked = 0;
    int          locked_cycles = 0;
    bit          last_was_dbg = 1;
    logic        e_cpu_gnt = 0, e_dbg_gnt = 0, e_mem_en = 0, e_mem_we = 0;
    logic        e_cpu_rvalid = 0, e_dbg_rvalid = 0;
    logic [15:0] e_mem_addr = 0, e_mem_din = 0, e_rdata = 0;

    initial for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);

    task automatic model_edge();
        int winner;          // 0 none, 1 cpu, 2 debug
        bit timed_out, blocks, cw, dw, rc, rd;
        logic [15:0] rv;
        // The access issued in the cycle now ending completes at this edge.
        rc = e_mem_en && !e_mem_we && e_cpu_gnt;
        rd = e_mem_en && !e_mem_we && e_dbg_gnt;
        rv = (rc || rd) ? ref_mem[e_mem_addr] : 16'd0;
        if (e_mem_en && e_mem_we) ref_mem[e_mem_addr] = e_mem_din;
        model_live = 1;
        if (rst) begin
            locked = 0; locked_cycles = 0; last_was_dbg = 1;
            e_cpu_gnt = 0; e_dbg_gnt = 0; e_mem_en = 0; e_mem_we = 0;
            e_mem_addr = 0; e_mem_din = 0; e_cpu_rvalid = 0; e_dbg_rvalid = 0; e_rdata = 0;
            return;
        end
        timed_out = 0;
        if (locked) begin
            locked_cycles++;
            timed_out = (locked_cycles >= LOCK_MAX);
        end
        blocks = locked && dbg_lock && !timed_out;
        cw = cpu_req && !e_cpu_gnt && !blocks;
        dw = dbg_req && !e_dbg_gnt;
        if (cw && (!dw || timed_out || last_was_dbg)) winner = 1;
        else if (dw) winner = 2;
        else winner = 0;
        if (!blocks) begin
            if (winner == 2 && dbg_lock) begin locked = 1; locked_cycles = 0; end
            else locked = 0;
        end
        e_cpu_gnt = (winner == 1);
        e_dbg_gnt = (winner == 2);
        e_mem_en  = (winner != 0);
        e_mem_we  = 0;
        if (winner == 1) begin
            e_mem_we = cpu_we; e_mem_addr = cpu_addr; e_mem_din = cpu_din; last_was_dbg = 0;
        end else if (winner == 2) begin
            e_mem_we = dbg_we; e_mem_addr = dbg_addr; e_mem_din = dbg_din; last_was_dbg = 1;
        end
        e_cpu_rvalid = rc;
        e_dbg_rvalid = rd;
        e_rdata = rv;
    endtask

    always @(posedge clk) model_edge();

    // Compare process: every cycle once the model has seen an edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk1("cpu_gnt", cpu_gnt, e_cpu_gnt);
            chk1("dbg_gnt", dbg_gnt, e_dbg_gnt);
            chk1("mem_en", mem_en, e_mem_en);
            chk1("mem_we", mem_we, e_mem_we);
            chk1("cpu_rvalid", cpu_rvalid, e_cpu_rvalid);
            chk1("dbg_rvalid", dbg_rvalid, e_dbg_rvalid);
            chk16("mem_addr", mem_addr, e_mem_addr);
            chk16("mem_din", mem_din, e_mem_din);
            chk16("rdata", rdata, e_rdata);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic all_zero(input string nm);
        chk1({nm, "_mem_en"}, mem_en, 1'b0);
        chk1({nm, "_mem_we"}, mem_we, 1'b0);
        chk16({nm, "_mem_addr"}, mem_addr, 16'h0000);
        chk16({nm, "_mem_din"}, mem_din, 16'h0000);
        chk1({nm, "_cpu_gnt"}, cpu_gnt, 1'b0);
        chk1({nm, "_dbg_gnt"}, dbg_gnt, 1'b0);
        chk1({nm, "_cpu_rvalid"}, cpu_rvalid, 1'b0);
        chk1({nm, "_dbg_rvalid"}, dbg_rvalid, 1'b0);
        chk16({nm, "_rdata"}, rdata, 16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] pat_c;
        logic [4:0] pat_d;
        logic       exp_c;

        // Reset state.
        rst = 1'b1;
        repeat (2) tick();
        all_zero("reset");

        // Single CPU read from 0x3000.
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        tick();
        chk1("rd_gnt", cpu_gnt, 1'b1);
        chk1("rd_en", mem_en, 1'b1);
        chk16("rd_addr", mem_addr, 16'h3000);
        cpu_req = 1'b0;
        tick();
        chk1("rd_rvalid", cpu_rvalid, 1'b1);
        chk16("rd_rdata", rdata, 16'hABCD);
        tick();
        chk1("rd_rvalid_once", cpu_rvalid, 1'b0);

        // Simultaneous writes straight out of reset.
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4000; cpu_din = 16'h0001;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h4001; dbg_din = 16'h0002;
        tick();
        rst = 1'b0;
        tick();
        chk1("tie_cpu_first", cpu_gnt, 1'b1);
        chk1("tie_dbg_wait", dbg_gnt, 1'b0);
        cpu_req = 1'b0;
        tick();
        chk1("tie_dbg_next", dbg_gnt, 1'b1);
        chk16("tie_dbg_addr", mem_addr, 16'h4001);
        dbg_req = 1'b0;
        tick();
        chk1("wr_no_crv", cpu_rvalid, 1'b0);
        chk1("wr_no_drv", dbg_rvalid, 1'b0);
        tick();
        chk16("wr_mem4000", mem[16'h4000], 16'h0001);
        chk16("wr_mem4001", mem[16'h4001], 16'h0002);

        // Continuous contention: strict alternation.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h3001;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_c = (i % 2 == 0);
            chk1("alt_en", mem_en, 1'b1);
            chk1("alt_cpu", cpu_gnt, exp_c);
            chk1("alt_dbg", dbg_gnt, !exp_c);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (2) tick();

        // Lock timeout with LOCK_MAX = 4.
        do_reset();
        dbg_req = 1'b1; dbg_lock = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h5000; dbg_din = 16'h1234;
        tick();
        chk1("lock_enter", dbg_gnt, 1'b1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h5001; cpu_din = 16'h4321;
        pat_c = 5'b01000;   // bit k: cycle k after the lock-entry cycle
        pat_d = 5'b10010;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk1("lock_cpu", cpu_gnt, pat_c[k]);
            chk1("lock_dbg", dbg_gnt, pat_d[k]);
            if (pat_c[k]) cpu_req = 1'b0;
        end
        dbg_req = 1'b0; dbg_lock = 1'b0; cpu_req = 1'b0;
        repeat (2) tick();

        // Reset during a read's issue cycle.
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
        tick();
        chk1("rr_issue", cpu_gnt, 1'b1);
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        all_zero("rr_after");
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3002;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h3003;
        tick();
        chk1("rr_tie_cpu", cpu_gnt, 1'b1);
        chk1("rr_tie_dbg", dbg_gnt, 1'b0);
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (2) tick();

        // Randomized traffic with holding requesters, random locks and resets.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            if (!cpu_req || cpu_gnt) begin
                if ($urandom_range(0, 2) != 0) begin
                    cpu_req  = 1'b1;
                    cpu_we   = 1'($urandom_range(0, 1));
                    cpu_addr = 16'h3000 + 16'($urandom_range(0, 7));
                    cpu_din  = 16'($urandom);
                end else begin
                    cpu_req = 1'b0;
                end
            end
            if (!dbg_req || dbg_gnt) begin
                if ($urandom_range(0, 2) != 0) begin
                    dbg_req  = 1'b1;
                    dbg_we   = 1'($urandom_range(0, 1));
                    dbg_addr = 16'h3000 + 16'($urandom_range(0, 7));
                    dbg_din  = 16'($urandom);
                end else begin
                    dbg_req = 1'b0;
                end
            end
            if ($urandom_range(0, 19) == 0) dbg_lock = ~dbg_lock;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
